// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side consumer for the async FIFO. Pulls words through the FIFO read
// port into a 3-entry prefetch buffer and presents them as a valid/ready
// stream. rd_en depends only on registered occupancy and rd_empty, so there
// is no combinational path from out_ready back into the FIFO.
// Optional feature macro: FIFO_STREAM_READER_LAST_EN (burst-boundary out_last).

// Companion checker: occupancy and stream-stability properties.
module fifo_stream_reader_chk #(
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  push,
  input logic                  pop,
  input logic [1:0]            count,
  input logic                  out_valid,
  input logic                  out_ready,
  input logic [DATA_WIDTH-1:0] out_data,
  input logic                  out_last
);

  // A push into a full buffer without a matching pop would overwrite data.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == 2'd3)));

  // A stalled beat must hold its payload until it is taken.
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

endmodule

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  out_count
);

  if (BURST_LEN < 32'sd1) begin : g_burst_len_check
    $error("fifo_stream_reader: BURST_LEN must be at least 1");
  end

  // Circular pointer advance over three slots: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    ptr_inc = (ptr == 2'd2) ? 2'd0 : (ptr + 2'd1);
  endfunction

  logic [DATA_WIDTH-1:0] buf_r [0:2];
  logic [1:0]            head_r;
  logic [1:0]            tail_r;
  logic [1:0]            count_r;
  logic [1:0]            count_next_s;
  logic                  inflight_r;
  logic [CNT_WIDTH-1:0]  xfer_cnt_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  rd_accept_s;

  // Read request: space for one more word counting the one already in flight.
  // A pop in the same cycle is deliberately not credited.
  always_comb begin
    rd_en = 1'b0;
    if (rd_rst_n && !rd_empty && (({1'b0, count_r} + {2'b00, inflight_r}) < 3'd3)) begin
      rd_en = 1'b1;
    end else begin
      rd_en = 1'b0;
    end
  end

  // Handshake decode: read data lands one cycle after an accepted read.
  always_comb begin
    rd_accept_s = rd_en && !rd_empty;
    push_s      = inflight_r;
    pop_s       = out_valid && out_ready;
  end

  // Occupancy update: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Control state: pointers, occupancy, in-flight flag and transfer counter.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      head_r     <= 2'd0;
      tail_r     <= 2'd0;
      count_r    <= 2'd0;
      inflight_r <= 1'b0;
      xfer_cnt_r <= '0;
    end else begin
      inflight_r <= rd_accept_s;
      count_r    <= count_next_s;
      if (push_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r     <= ptr_inc(head_r);
        xfer_cnt_r <= xfer_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  // Buffer storage: capture the in-flight FIFO word at the tail slot.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        buf_r[i] <= '0;
      end
    end else if (push_s) begin
      buf_r[tail_r] <= rd_data;
    end
  end

  // Stream outputs driven straight from registered buffer state.
  always_comb begin
    out_valid = (count_r != 2'd0);
    out_data  = buf_r[head_r];
    out_count = xfer_cnt_r;
  end

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] beat_r;

  // Beat position within the current burst; advances once per transfer.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      beat_r <= '0;
    end else if (pop_s) begin
      if (beat_r == BEAT_MAX) begin
        beat_r <= '0;
      end else begin
        beat_r <= beat_r + BEAT_W'(1);
      end
    end
  end

  // Last-beat flag follows the head beat, so it is stable while stalled.
  always_comb begin
    out_last = 1'b0;
    if (out_valid && (beat_r == BEAT_MAX)) begin
      out_last = 1'b1;
    end else begin
      out_last = 1'b0;
    end
  end
`else
  // Burst tracking not built: no beat is ever marked last.
  always_comb begin
    out_last = 1'b0;
  end
`endif

  fifo_stream_reader_chk #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_chk (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .count     (count_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader. A queue-based FIFO model feeds the read
// port; a reference model tracks words owned by the reader (accepted reads
// minus transfers) and the in-order word stream.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] out_count;

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .rd_clk    (rd_clk),
    .rd_rst_n  (rd_rst_n),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_empty  (rd_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_count (out_count)
  );

  always #5 rd_clk = ~rd_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int unsigned   a_cnt;
  int unsigned   t_cnt;
  bit            acc_prev;
  logic [DW-1:0] infl_word;

  // Values sampled in the most recent cycle
  bit            s_rden;
  bit            s_valid;
  bit            s_last;
  bit            s_xfer;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_count;

  typedef struct {
    bit          ready;
    bit          rden;
    bit          valid;
    logic [DW-1:0] data;
    int unsigned cnt;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    fifo_q.delete();
    exp_q.delete();
    a_cnt    = 0;
    t_cnt    = 0;
    acc_prev = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit ready, input bit gap);
    int unsigned occ;
    int unsigned buf_words;
    bit e_rden;
    bit e_valid;
    bit e_last;
    bit acc;
    if (acc_prev) rd_data = infl_word;
    rd_empty  = (fifo_q.size() == 0) || gap;
    out_ready = ready;
    #1;
    occ       = a_cnt - t_cnt;
    buf_words = occ - (acc_prev ? 1 : 0);
    e_rden    = !rd_empty && (occ < 3);
    e_valid   = (buf_words != 0);
`ifdef FIFO_STREAM_READER_LAST_EN
    e_last    = e_valid && ((t_cnt % BL) == (BL - 1));
`else
    e_last    = 1'b0;
`endif
    check("rd_en", rd_en, e_rden);
    check("out_valid", out_valid, e_valid);
    check("out_count", out_count, t_cnt % (1 << CW));
    check("out_last", out_last, e_last);
    if (e_valid && exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
    s_rden  = rd_en;
    s_valid = out_valid;
    s_last  = out_last;
    s_data  = out_data;
    s_count = out_count;
    acc     = rd_en && !rd_empty;
    s_xfer  = out_valid && out_ready;
    if (s_xfer) begin
      if (exp_q.size() == 0) begin
        check("xfer_without_word", 1, 0);
      end else begin
        void'(exp_q.pop_front());
        t_cnt++;
      end
    end
    if (acc) begin
      infl_word = fifo_q.pop_front();
      exp_q.push_back(infl_word);
      a_cnt++;
    end
    acc_prev = acc;
    @(negedge rd_clk);
  endtask

  initial begin
    int unsigned acc_before;
    int first_i;
    int last_i;
    int n;
    int sent;
    int cycles;
    int unsigned start_t;
    int unsigned tb_idx;
    logic [9:0] mask;
    logic [9:0] exp_mask;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,  0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h11, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h22, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h33, 2};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0,  3};

    // Reset held with a non-empty FIFO
    rd_rst_n  = 1'b0;
    out_ready = 1'b0;
    rd_data   = '0;
    reset_model();
    fifo_q.push_back(32'h11);
    fifo_q.push_back(32'h22);
    fifo_q.push_back(32'h33);
    rd_empty = 1'b0;
    repeat (3) @(negedge rd_clk);
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_data", out_data, 0);
    rd_rst_n = 1'b1;

    // Preloaded 0x11,0x22,0x33 with out_ready high
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].ready, 1'b0);
      check("tbl_rd_en", s_rden, tbl[i].rden);
      check("tbl_out_valid", s_valid, tbl[i].valid);
      if (tbl[i].valid) check("tbl_out_data", s_data, tbl[i].data);
      check("tbl_out_count", s_count, tbl[i].cnt);
    end

    // Eight words queued, downstream stalled, then released
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'hA0 + 32'(i));
    acc_before = a_cnt;
    repeat (6) cycle(1'b0, 1'b0);
    check("stall_reads", a_cnt - acc_before, 3);
    check("stall_head", s_data, 32'hA0);
    first_i = -1;
    last_i  = -1;
    n       = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0);
      if (s_xfer) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        n++;
      end
    end
    check("stall_xfers", n, 8);
    check("stall_no_gap", last_i - first_i, 7);

    // Randomized traffic against the reference model
    sent    = 0;
    cycles  = 0;
    start_t = t_cnt;
    while ((t_cnt - start_t) < 1000 && cycles < 20000) begin
      if (sent < 1000 && fifo_q.size() < 4 && $urandom_range(0, 1) == 1) begin
        fifo_q.push_back($urandom);
        sent++;
      end
      cycle(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      cycles++;
    end
    check("rand_done", t_cnt - start_t, 1000);

    // Asynchronous reset with two buffered words and one in flight
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'hB0 + 32'(i));
    repeat (3) cycle(1'b0, 1'b0);
    rd_rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_rd_en", rd_en, 0);
    check("arst_out_count", out_count, 0);
    reset_model();
    rd_empty = 1'b1;
    repeat (2) @(negedge rd_clk);
    rd_rst_n = 1'b1;

    // Fresh words after reset: burst marks and counter wrap
    for (int i = 0; i < 17; i++) fifo_q.push_back(32'hC0 + 32'(i));
    mask   = '0;
    cycles = 0;
    while (t_cnt < 17 && cycles < 100) begin
      tb_idx = t_cnt;
      cycle(1'b1, 1'b0);
      if (s_xfer && tb_idx < 10) mask[tb_idx] = s_last;
      cycles++;
    end
`ifdef FIFO_STREAM_READER_LAST_EN
    exp_mask = 10'b0010001000;
`else
    exp_mask = 10'b0000000000;
`endif
    check("burst_last", mask, exp_mask);
    #1;
    check("cnt_wrap", out_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
